hub_align_stage: RTL and testbench

//  Pipelined operand-alignment stage of the FP HUB adder; sits directly upstream of the shifter.

---
 rtl/hub_align_stage.sv | 174 +++++++++++++++++
 tb/tb_hub_align_stage.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hub_align_stage.sv
`default_nettype none
// ============================================================================
//  Module      : hub_align_stage
//  Description : Operand-alignment stage of the FP HUB adder. Unpacks X and Y
//                into extended HUB mantissas, orders them by magnitude and
//                produces the shifter controls that align the smaller operand.
//                Two-stage pipeline with a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module hub_align_stage #(
    parameter int M                   = 23,
    parameter int E                   = 8,
    parameter int EXTRA_BITS_MANTISSA = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [E+M:0]     x,
    input  logic [E+M:0]     y,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sign_large,
    output logic             eff_sub,
    output logic [E-1:0]     exp_large,
    output logic [M+EXTRA_BITS_MANTISSA-1:0] mant_large,
    output logic [M+EXTRA_BITS_MANTISSA-1:0] mant_small,
    output logic [E:0]       shift_amount,
    output logic             right_shift,
    output logic             arithmetic_shift
);

    localparam int XB = EXTRA_BITS_MANTISSA;
    localparam int W  = M + XB;

    // Largest useful alignment distance: beyond W every bit is shifted out.
    localparam logic [E:0] c_W_SAT = (E+1)'(W);

    // ------------------------------------------------------------------
    // Operand unpacking
    // ------------------------------------------------------------------
    logic          w_sx;
    logic          w_sy_eff;
    logic [E-1:0]  w_ex;
    logic [E-1:0]  w_ey;
    logic [M-1:0]  w_mx;
    logic [M-1:0]  w_my;

    assign w_sx     = x[E+M];
    assign w_sy_eff = y[E+M] ^ op_sub;   // subtraction flips Y's sign
    assign w_ex     = x[E+M-1:M];
    assign w_ey     = y[E+M-1:M];
    assign w_mx     = x[M-1:0];
    assign w_my     = y[M-1:0];

    // Low part of the extended mantissa: the ILSB followed by zero padding.
    logic [XB-2:0] w_tail;

    generate
        if (XB > 2) begin : g_tail_pad
            assign w_tail = {1'b1, {(XB-2){1'b0}}};
        end else begin : g_tail_ilsb
            assign w_tail = 1'b1;
        end
    endgenerate

    // Extended mantissas; a zero exponent encodes zero, so nothing is set,
    // not even the ILSB.
    logic [W-1:0] w_ext_x;
    logic [W-1:0] w_ext_y;

    assign w_ext_x = (w_ex != '0) ? {1'b1, w_mx, w_tail} : '0;
    assign w_ext_y = (w_ey != '0) ? {1'b1, w_my, w_tail} : '0;

    // Magnitude ordering on raw fields; full equality keeps X as large.
    logic w_swap;

    assign w_swap = (w_ey > w_ex) || ((w_ey == w_ex) && (w_my > w_mx));

    // Signed exponent difference in E+1 bits.
    logic [E:0] w_diff;

    assign w_diff = {1'b0, w_ex} - {1'b0, w_ey};

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic r_s1_valid;
    logic w_adv2;
    logic w_adv1;

    assign w_adv2   = !out_valid || out_ready;
    assign w_adv1   = !r_s1_valid || w_adv2;
    assign in_ready = w_adv1;

    // Shifter direction controls are fixed.
    assign right_shift      = 1'b1;
    assign arithmetic_shift = 1'b0;

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic          r_s1_sign_large;
    logic          r_s1_eff_sub;
    logic [E-1:0]  r_s1_exp_large;
    logic [W-1:0]  r_s1_mant_large;
    logic [W-1:0]  r_s1_mant_small;
    logic [E:0]    r_s1_diff;

    // Stage 1: capture the unpacked, magnitude-ordered operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid      <= 1'b0;
            r_s1_sign_large <= 1'b0;
            r_s1_eff_sub    <= 1'b0;
            r_s1_exp_large  <= '0;
            r_s1_mant_large <= '0;
            r_s1_mant_small <= '0;
            r_s1_diff       <= '0;
        end else if (w_adv1) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_eff_sub <= w_sx ^ w_sy_eff;
                r_s1_diff    <= w_diff;
                if (w_swap) begin
                    r_s1_sign_large <= w_sy_eff;
                    r_s1_exp_large  <= w_ey;
                    r_s1_mant_large <= w_ext_y;
                    r_s1_mant_small <= w_ext_x;
                end else begin
                    r_s1_sign_large <= w_sx;
                    r_s1_exp_large  <= w_ex;
                    r_s1_mant_large <= w_ext_x;
                    r_s1_mant_small <= w_ext_y;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: absolute distance with saturation
    // ------------------------------------------------------------------
    logic [E:0] w_abs_diff;
    logic [E:0] w_shift_sat;

    assign w_abs_diff  = r_s1_diff[E] ? (~r_s1_diff + {{E{1'b0}}, 1'b1}) : r_s1_diff;
    assign w_shift_sat = (w_abs_diff > c_W_SAT) ? c_W_SAT : w_abs_diff;

    // Stage 2: output registers, frozen while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            sign_large   <= 1'b0;
            eff_sub      <= 1'b0;
            exp_large    <= '0;
            mant_large   <= '0;
            mant_small   <= '0;
            shift_amount <= '0;
        end else if (w_adv2) begin
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                sign_large   <= r_s1_sign_large;
                eff_sub      <= r_s1_eff_sub;
                exp_large    <= r_s1_exp_large;
                mant_large   <= r_s1_mant_large;
                mant_small   <= r_s1_mant_small;
                shift_amount <= w_shift_sat;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hub_align_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hub_align_stage
//  Description : Directed, table-driven bench for hub_align_stage with
//                hand-written stall and reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hub_align_stage;

    localparam int N = 13;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic [31:0] y;
    logic        op_sub;
    logic        out_valid;
    logic        out_ready;
    logic        sign_large;
    logic        eff_sub;
    logic [7:0]  exp_large;
    logic [29:0] mant_large;
    logic [29:0] mant_small;
    logic [8:0]  shift_amount;
    logic        right_shift;
    logic        arithmetic_shift;

    hub_align_stage #(
        .M                   (23),
        .E                   (8),
        .EXTRA_BITS_MANTISSA (7)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .x                (x),
        .y                (y),
        .op_sub           (op_sub),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .sign_large       (sign_large),
        .eff_sub          (eff_sub),
        .exp_large        (exp_large),
        .mant_large       (mant_large),
        .mant_small       (mant_small),
        .shift_amount     (shift_amount),
        .right_shift      (right_shift),
        .arithmetic_shift (arithmetic_shift)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        op_sub;
        logic        sign_large;
        logic        eff_sub;
        logic [7:0]  exp_large;
        logic [29:0] mant_large;
        logic [29:0] mant_small;
        logic [8:0]  shift;
    } vec_t;

    vec_t vecs [N];
    int   checks = 0;
    int   errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic apply(input vec_t v);
        x      = v.x;
        y      = v.y;
        op_sub = v.op_sub;
    endtask

    task automatic check_vec(input vec_t v, input string tag);
        chk({tag, ".sign_large"},   32'(sign_large),   32'(v.sign_large));
        chk({tag, ".eff_sub"},      32'(eff_sub),      32'(v.eff_sub));
        chk({tag, ".exp_large"},    32'(exp_large),    32'(v.exp_large));
        chk({tag, ".mant_large"},   32'(mant_large),   32'(v.mant_large));
        chk({tag, ".mant_small"},   32'(mant_small),   32'(v.mant_small));
        chk({tag, ".shift_amount"}, 32'(shift_amount), 32'(v.shift));
    endtask

    initial begin
        int sent;
        int got;
        int ncyc;

        //            x             y             sub   sgn   eff   exp      mant_large     mant_small     shift
        vecs[0]  = '{32'h3F800000, 32'h3F000000, 1'b0, 1'b0, 1'b0, 8'd127, 30'h20000020, 30'h20000020, 9'd1};
        vecs[1]  = '{32'h3F000000, 32'h3F800000, 1'b0, 1'b0, 1'b0, 8'd127, 30'h20000020, 30'h20000020, 9'd1};
        vecs[2]  = '{32'h53800000, 32'h3F800000, 1'b0, 1'b0, 1'b0, 8'd167, 30'h20000020, 30'h20000020, 9'd30};
        vecs[3]  = '{32'h3FC00000, 32'hBFE00000, 1'b0, 1'b1, 1'b1, 8'd127, 30'h38000020, 30'h30000020, 9'd0};
        vecs[4]  = '{32'h3F800000, 32'h00000000, 1'b0, 1'b0, 1'b0, 8'd127, 30'h20000020, 30'h00000000, 9'd30};
        vecs[5]  = '{32'h3F800000, 32'h3F800000, 1'b1, 1'b0, 1'b1, 8'd127, 30'h20000020, 30'h20000020, 9'd0};
        vecs[6]  = '{32'hC0000000, 32'h40400000, 1'b1, 1'b1, 1'b0, 8'd128, 30'h30000020, 30'h20000020, 9'd0};
        vecs[7]  = '{32'h4E800000, 32'h3F800000, 1'b0, 1'b0, 1'b0, 8'd157, 30'h20000020, 30'h20000020, 9'd30};
        vecs[8]  = '{32'h4F000000, 32'h3F800000, 1'b0, 1'b0, 1'b0, 8'd158, 30'h20000020, 30'h20000020, 9'd30};
        vecs[9]  = '{32'h4E000000, 32'h3F800000, 1'b0, 1'b0, 1'b0, 8'd156, 30'h20000020, 30'h20000020, 9'd29};
        vecs[10] = '{32'h00000000, 32'hFF800000, 1'b0, 1'b1, 1'b1, 8'd255, 30'h20000020, 30'h00000000, 9'd30};
        vecs[11] = '{32'h80000000, 32'h00000000, 1'b0, 1'b1, 1'b1, 8'd0,   30'h00000000, 30'h00000000, 9'd0};
        vecs[12] = '{32'hBF800000, 32'hBF800001, 1'b1, 1'b0, 1'b1, 8'd127, 30'h20000060, 30'h20000020, 9'd0};

        // Reset
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = '0;
        y         = '0;
        op_sub    = 1'b0;
        step();
        chk("rst_right_shift", 32'(right_shift), 32'd1);
        chk("rst_arith_shift", 32'(arithmetic_shift), 32'd0);
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        chk("post_rst_in_ready",  32'(in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        chk("post_rst_exp",       32'(exp_large), 32'd0);
        chk("post_rst_mant_large", 32'(mant_large), 32'd0);
        chk("post_rst_mant_small", 32'(mant_small), 32'd0);
        chk("post_rst_shift",     32'(shift_amount), 32'd0);

        // Single transactions: latency exactly 2
        for (int i = 0; i < N; i++) begin
            apply(vecs[i]);
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            chk($sformatf("single%0d.valid_early", i), 32'(out_valid), 32'd0);
            step();
            chk($sformatf("single%0d.valid", i), 32'(out_valid), 32'd1);
            check_vec(vecs[i], $sformatf("single%0d", i));
            step();
        end

        // Back-to-back stream: one per cycle
        sent = 0;
        got  = 0;
        ncyc = 0;
        out_ready = 1'b1;
        while (ncyc < 40 && got < N) begin
            if (sent < N) begin
                apply(vecs[sent]);
                in_valid = 1'b1;
                chk("stream_in_ready", 32'(in_ready), 32'd1);
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid) begin
                check_vec(vecs[got], $sformatf("stream%0d", got));
                got++;
            end
            if (in_valid && in_ready) sent++;
            step();
            ncyc++;
        end
        in_valid = 1'b0;
        chk("stream_count",  32'(got),  32'(N));
        chk("stream_cycles", 32'(ncyc), 32'(N + 2));

        // Backpressure: two accepted, third blocked, outputs held
        out_ready = 1'b0;
        apply(vecs[0]);
        in_valid = 1'b1;
        chk("t6_accept_a", 32'(in_ready), 32'd1);
        step();
        apply(vecs[3]);
        chk("t6_accept_b", 32'(in_ready), 32'd1);
        step();
        apply(vecs[6]);
        chk("t6_block_c",  32'(in_ready), 32'd0);
        chk("t6_valid",    32'(out_valid), 32'd1);
        step();
        step();
        chk("t6_still_blocked", 32'(in_ready), 32'd0);
        chk("t6_hold_valid",    32'(out_valid), 32'd1);
        check_vec(vecs[0], "t6_hold");

        // Release and drain in order
        out_ready = 1'b1;
        sent = 2;
        got  = 0;
        ncyc = 0;
        while (ncyc < 20 && got < 3) begin
            if (out_valid && out_ready) begin
                case (got)
                    0: check_vec(vecs[0], "t6_out0");
                    1: check_vec(vecs[3], "t6_out1");
                    default: check_vec(vecs[6], "t6_out2");
                endcase
                got++;
            end
            if (in_valid && in_ready) sent++;
            step();
            in_valid = (sent < 3);
            ncyc++;
        end
        chk("t6_drain_count", 32'(got),  32'd3);
        chk("t6_sent_count",  32'(sent), 32'd3);
        step();
        chk("t6_no_dup", 32'(out_valid), 32'd0);

        // Reset during a stall discards everything
        out_ready = 1'b0;
        apply(vecs[2]);
        in_valid = 1'b1;
        step();
        apply(vecs[4]);
        step();
        in_valid = 1'b0;
        chk("rst_stall_pre_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        step();
        chk("rst_stall_valid",       32'(out_valid), 32'd0);
        chk("rst_stall_exp",         32'(exp_large), 32'd0);
        chk("rst_stall_mant_large",  32'(mant_large), 32'd0);
        chk("rst_stall_shift",       32'(shift_amount), 32'd0);
        chk("rst_stall_right_shift", 32'(right_shift), 32'd1);
        rst = 1'b0;
        chk("rst_stall_in_ready", 32'(in_ready), 32'd1);
        step();
        chk("rst_stall_flushed", 32'(out_valid), 32'd0);
        step();
        chk("rst_stall_flushed2", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
